alarm_clock_ctrl: RTL
=====================

ALARM_CLOCK_CTRL -- requirements
Module: alarm_clock_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clock cycles per second.
REQ-002 Parameter RING_SECS, default 60, alarm ring duration in seconds.
REQ-003 Parameter SNOOZE_SECS, default 300, snooze delay in seconds (used only under REQ-033).
REQ-004 clk  input  1  system clock; single clock domain; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_mode  input  1  debounced one-cycle pulse; cycles the operating mode.
REQ-007 btn_next  input  1  debounced one-cycle pulse; selects the next field while setting.
REQ-008 btn_inc  input  1  debounced one-cycle pulse; increments the selected field; clears the ring.
REQ-009 settime  output  1  high in SET_TIME or SET_ALARM; drives display colour select.
REQ-010 hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB  output  4 each  current time, BCD.
REQ-011 alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB  output  4 each  alarm time, BCD.
REQ-012 field_sel  output  2  selected field: 0 hour, 1 min, 2 sec.
REQ-013 alarm_ring  output  1  high while the alarm sounds.

Function
REQ-014 Prescaler counts 0..CLK_HZ-1; internal tick asserted for one cycle at count CLK_HZ-1.
REQ-015 FSM states RUN, SET_TIME, SET_ALARM; btn_mode transitions RUN->SET_TIME->SET_ALARM->RUN.
REQ-016 Button priority within a cycle: btn_mode > btn_next > btn_inc; lower-priority pulses in the same cycle are ignored.
REQ-017 On entry to SET_TIME or SET_ALARM, field_sel becomes 0 (hour).
REQ-018 btn_next sequence: 0->1->2->0; ignored in RUN.
REQ-019 btn_inc in SET_TIME increments the selected time field; in SET_ALARM, the selected alarm field; no carry to the next field.
REQ-020 Field wrap: hour 23->00, minute 59->00, second 59->00; BCD LSB 9->0 increments MSB.
REQ-021 In SET_TIME, the prescaler is held at 0 and time does not advance.
REQ-022 In RUN and SET_ALARM, each tick advances time by one second with full carry; 23:59:59 wraps to 00:00:00.
REQ-023 Digit outputs are registered; a tick or btn_inc at cycle N is visible at cycle N+1.
REQ-024 Alarm match: in RUN, a tick whose updated time equals the alarm time sets alarm_ring at cycle N+1.
REQ-025 The ring counter decrements on each tick; alarm_ring clears after RING_SECS ticks.
REQ-026 btn_inc in RUN while alarm_ring is high clears alarm_ring next cycle; the time is unchanged.
REQ-027 btn_mode clears alarm_ring and the ring counter.
REQ-028 A match that occurs while already ringing restarts nothing.
REQ-029 Time edits in SET_TIME never trigger a match.

Reset
REQ-030 On reset: state RUN, prescaler 0, time 00:00:00, alarm 07:00:00, field_sel 0, settime 0, alarm_ring 0, ring/snooze counters 0.
REQ-031 Reset overrides all buttons and ticks in the same cycle.
REQ-032 Reset during SET_TIME returns to RUN, with the time counters cleared.

Configuration
REQ-033 Macro ALARM_SNOOZE_EN defined: btn_inc during ring clears alarm_ring and loads the snooze counter with SNOOZE_SECS; when the count expires in RUN, alarm_ring reasserts once for RING_SECS; btn_mode cancels the snooze.
REQ-034 Macro ALARM_SNOOZE_EN undefined: no snooze counter; btn_inc only clears the ring (REQ-026).

Structure
REQ-035 Package alarm_clock_pkg SHALL hold the state enum (RUN, SET_TIME, SET_ALARM), the field enum (HOUR, MIN, SEC), and the BCD limit constants (23, 59).
REQ-036 Sub-module bcd_mod_counter: two-digit BCD register with max-value parameter, inc input, load/clear, and carry-out on wrap; six instances (three time, three alarm).

Verification
REQ-037 Reset, then CLK_HZ=10 and 10 ticks in RUN -> time 00:00:10, settime 0.
REQ-038 Time preloaded 23:59:59, one tick -> 00:00:00 on the next cycle.
REQ-039 Mode x1, inc x3 -> hour 03; next, inc x60 -> minute 00 with no carry into hour; no time advance across 100 cycles.
REQ-040 Alarm 07:00:00, time 06:59:59, RUN, tick -> alarm_ring 1 at N+1; after 60 ticks -> 0; btn_inc mid-ring -> 0 next cycle.
REQ-041 Same cycle btn_mode and btn_inc in SET_TIME -> state SET_ALARM, hour unchanged.
REQ-042 With ALARM_SNOOZE_EN and SNOOZE_SECS=5, btn_inc during ring -> ring 0, then reasserts after 5 ticks.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared states, field selectors and BCD limits for the alarm clock
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOUR = 2'd0,
        MIN  = 2'd1,
        SEC  = 2'd2
    } field_t;

    localparam logic [7:0] HOUR_MAX_BCD   = 8'h23;
    localparam logic [7:0] MINSEC_MAX_BCD = 8'h59;
    localparam logic [7:0] ALARM_HOUR_RST = 8'h07;

    // Field selection order while setting: hour -> minute -> second -> hour.
    function automatic field_t next_field(input field_t f);
        case (f)
            HOUR:    return MIN;
            MIN:     return SEC;
            default: return HOUR;
        endcase
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// rtl/alarm_clock_ctrl_if.sv - button inputs and display/alarm outputs of the alarm clock
interface alarm_clock_ctrl_if;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic       settime;
    logic [3:0] hourMSB;
    logic [3:0] hourLSB;
    logic [3:0] minMSB;
    logic [3:0] minLSB;
    logic [3:0] secMSB;
    logic [3:0] secLSB;
    logic [3:0] alarmhourMSB;
    logic [3:0] alarmhourLSB;
    logic [3:0] alarmminMSB;
    logic [3:0] alarmminLSB;
    logic [3:0] alarmsecMSB;
    logic [3:0] alarmsecLSB;
    logic [1:0] field_sel;
    logic       alarm_ring;

    modport master (
        output btn_mode, btn_next, btn_inc,
        input  settime, hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB,
        input  alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB,
        input  field_sel, alarm_ring
    );

    modport slave (
        input  btn_mode, btn_next, btn_inc,
        output settime, hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB,
        output alarmhourMSB, alarmhourLSB, alarmminMSB, alarmminLSB, alarmsecMSB, alarmsecLSB,
        output field_sel, alarm_ring
    );
endinterface

// File: rtl/alarm_clock_ctrl_bcd_mod_counter.sv
// rtl/alarm_clock_ctrl_bcd_mod_counter.sv - two-digit BCD modulo counter with clear, load and wrap carry
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD   = 8'h59,
    parameter logic [7:0] RESET_BCD = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic [7:0] next_value,
    output logic       carry
);

    logic at_max;
    assign at_max = (value == MAX_BCD);

    // Carry is combinational so a chain of counters can ripple a full carry in one cycle.
    assign carry = inc && at_max;

    // Incremented value; next_value lets the owner look ahead (e.g. alarm match on the updated time).
    always_comb begin
        next_value = value;
        if (inc) begin
            if (at_max) begin
                next_value = 8'h00;
            end else if (value[3:0] == 4'd9) begin
                next_value = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    // Digit register: reset > clear > load > increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= RESET_BCD;
        end else if (clear) begin
            value <= 8'h00;
        end else if (load) begin
            value <= load_val;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - alarm clock controller; optional snooze when ALARM_SNOOZE_EN is defined
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic                     clk,
    input  logic                     reset,
    alarm_clock_ctrl_if.slave        bus
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = $clog2(RING_SECS + 1);

    state_t      state;
    field_t      field_sel;
    logic        settime;
    logic        alarm_ring;
    logic [RW-1:0] ring_cnt;
    logic [PW-1:0] presc;

`ifdef ALARM_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    logic [SW-1:0] snooze_cnt;
`else
    localparam int unsigned SNOOZE_UNUSED = SNOOZE_SECS;
`endif

    // Only the highest-priority button of a cycle takes effect.
    logic mode_press, next_press, inc_press;
    assign mode_press = bus.btn_mode;
    assign next_press = bus.btn_next && !bus.btn_mode;
    assign inc_press  = bus.btn_inc && !bus.btn_mode && !bus.btn_next;

    // Time is frozen while it is being edited.
    logic tick, tick_adv;
    assign tick     = (presc == PW'(CLK_HZ - 1));
    assign tick_adv = tick && (state != SET_TIME);

    logic edit_time, edit_alarm;
    assign edit_time  = inc_press && (state == SET_TIME);
    assign edit_alarm = inc_press && (state == SET_ALARM);

    // Prescaler producing the one-second tick; held at zero while setting the time.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (state == SET_TIME || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    logic [7:0] hour, min, sec, hour_next, min_next, sec_next;
    logic       hour_carry, min_carry, sec_carry;
    logic [7:0] a_hour, a_min, a_sec, a_hour_next, a_min_next, a_sec_next;
    logic       a_hour_carry, a_min_carry, a_sec_carry;

    // Ticks ripple the full carry chain; edits bump one field with no carry.
    logic sec_inc, min_inc, hour_inc;
    assign sec_inc  = tick_adv || (edit_time && field_sel == SEC);
    assign min_inc  = (tick_adv && sec_carry) || (edit_time && field_sel == MIN);
    assign hour_inc = (tick_adv && min_carry) || (edit_time && field_sel == HOUR);

    bcd_mod_counter #(.MAX_BCD(MINSEC_MAX_BCD), .RESET_BCD(8'h00)) u_sec (
        .clk(clk), .reset(reset), .inc(sec_inc), .clear(1'b0), .load(1'b0), .load_val(8'h00),
        .value(sec), .next_value(sec_next), .carry(sec_carry)
    );
    bcd_mod_counter #(.MAX_BCD(MINSEC_MAX_BCD), .RESET_BCD(8'h00)) u_min (
        .clk(clk), .reset(reset), .inc(min_inc), .clear(1'b0), .load(1'b0), .load_val(8'h00),
        .value(min), .next_value(min_next), .carry(min_carry)
    );
    bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD), .RESET_BCD(8'h00)) u_hour (
        .clk(clk), .reset(reset), .inc(hour_inc), .clear(1'b0), .load(1'b0), .load_val(8'h00),
        .value(hour), .next_value(hour_next), .carry(hour_carry)
    );

    bcd_mod_counter #(.MAX_BCD(MINSEC_MAX_BCD), .RESET_BCD(8'h00)) u_alarm_sec (
        .clk(clk), .reset(reset), .inc(edit_alarm && field_sel == SEC), .clear(1'b0), .load(1'b0),
        .load_val(8'h00), .value(a_sec), .next_value(a_sec_next), .carry(a_sec_carry)
    );
    bcd_mod_counter #(.MAX_BCD(MINSEC_MAX_BCD), .RESET_BCD(8'h00)) u_alarm_min (
        .clk(clk), .reset(reset), .inc(edit_alarm && field_sel == MIN), .clear(1'b0), .load(1'b0),
        .load_val(8'h00), .value(a_min), .next_value(a_min_next), .carry(a_min_carry)
    );
    bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD), .RESET_BCD(ALARM_HOUR_RST)) u_alarm_hour (
        .clk(clk), .reset(reset), .inc(edit_alarm && field_sel == HOUR), .clear(1'b0), .load(1'b0),
        .load_val(8'h00), .value(a_hour), .next_value(a_hour_next), .carry(a_hour_carry)
    );

    logic unused_sigs;
    assign unused_sigs = ^{hour_carry, a_hour_carry, a_min_carry, a_sec_carry,
                           a_hour_next, a_min_next, a_sec_next};

    // Match against the time as it will be after this tick, so the ring shows one cycle later.
    logic alarm_hit;
    assign alarm_hit = (state == RUN) && tick_adv &&
                       ({hour_next, min_next, sec_next} == {a_hour, a_min, a_sec});

    state_t mode_next;
    always_comb begin
        case (state)
            RUN:      mode_next = SET_TIME;
            SET_TIME: mode_next = SET_ALARM;
            default:  mode_next = RUN;
        endcase
    end

    // Mode FSM, field selection and ring/snooze control with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            field_sel  <= HOUR;
            settime    <= 1'b0;
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt <= '0;
`endif
        end else if (mode_press) begin
            state      <= mode_next;
            field_sel  <= HOUR;
            settime    <= (mode_next != RUN);
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt <= '0;
`endif
        end else begin
            if (next_press && state != RUN) begin
                field_sel <= next_field(field_sel);
            end
            if (inc_press && state == RUN && alarm_ring) begin
                alarm_ring <= 1'b0;
                ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
                snooze_cnt <= SW'(SNOOZE_SECS);
`endif
            end else if (alarm_ring) begin
                if (tick_adv) begin
                    if (ring_cnt <= RW'(1)) begin
                        alarm_ring <= 1'b0;
                        ring_cnt   <= '0;
                    end else begin
                        ring_cnt <= ring_cnt - RW'(1);
                    end
                end
            end else if (alarm_hit) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= RW'(RING_SECS);
            end
`ifdef ALARM_SNOOZE_EN
            else if (tick_adv && snooze_cnt != '0) begin
                snooze_cnt <= snooze_cnt - SW'(1);
                if (snooze_cnt == SW'(1) && state == RUN) begin
                    alarm_ring <= 1'b1;
                    ring_cnt   <= RW'(RING_SECS);
                end
            end
`endif
        end
    end

    assign bus.settime      = settime;
    assign bus.field_sel    = field_sel;
    assign bus.alarm_ring   = alarm_ring;
    assign bus.hourMSB      = hour[7:4];
    assign bus.hourLSB      = hour[3:0];
    assign bus.minMSB       = min[7:4];
    assign bus.minLSB       = min[3:0];
    assign bus.secMSB       = sec[7:4];
    assign bus.secLSB       = sec[3:0];
    assign bus.alarmhourMSB = a_hour[7:4];
    assign bus.alarmhourLSB = a_hour[3:0];
    assign bus.alarmminMSB  = a_min[7:4];
    assign bus.alarmminLSB  = a_min[3:0];
    assign bus.alarmsecMSB  = a_sec[7:4];
    assign bus.alarmsecLSB  = a_sec[3:0];

endmodule
